// File: rtl/matrix_loader.sv
// matrix_loader: frames a byte stream (one {row,col} header beat followed by row*col
// payload beats) for the spiral block. Latches row/col for the whole frame and
// forwards payload through a 2-entry FIFO with valid/ready handshakes.
module matrix_loader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned R_WIDTH    = 3,
  parameter int unsigned C_WIDTH    = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_rdy,
  output logic [R_WIDTH-1:0]    row,
  output logic [C_WIDTH-1:0]    col,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_rdy,
  output logic                  out_last,
  output logic                  hdr_err,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int unsigned CntW = R_WIDTH + C_WIDTH;

  typedef enum logic [1:0] {StHdr, StPayload, StDrain} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q;
  logic [CntW-1:0]       in_cnt_q, out_cnt_q;
  logic [R_WIDTH-1:0]    row_q;
  logic [C_WIDTH-1:0]    col_q;
  logic                  hdr_err_q, frame_done_q;

  logic [R_WIDTH-1:0]    hdr_row;
  logic [C_WIDTH-1:0]    hdr_col;
  logic                  hdr_ok, hdr_acc, push, pop, last_pop;
  logic [CntW-1:0]       frame_len;

  assign hdr_row   = in_data[R_WIDTH+C_WIDTH-1:C_WIDTH];
  assign hdr_col   = in_data[C_WIDTH-1:0];
  assign hdr_ok    = (hdr_row != '0) && (hdr_col != '0);
  assign frame_len = CntW'(hdr_row) * CntW'(hdr_col);

  // in_rdy depends only on registered state, never on in_valid.
  assign in_rdy = (state_q == StHdr) ||
                  ((state_q == StPayload) && (count_q != 2'd2) && (in_cnt_q != '0));

  assign hdr_acc  = in_valid && in_rdy && (state_q == StHdr);
  assign push     = in_valid && in_rdy && (state_q == StPayload);
  assign out_valid = (count_q != 2'd0);
  assign out_data = mem_q[rd_ptr_q];
  assign pop      = out_valid && out_rdy;
  assign last_pop = pop && (out_cnt_q == CntW'(1));
  assign out_last = out_valid && (out_cnt_q == CntW'(1));

  assign row        = row_q;
  assign col        = col_q;
  assign hdr_err    = hdr_err_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != StHdr);

  // Next-state: header -> payload -> drain, back to header on the final output handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StHdr:     if (hdr_acc && hdr_ok) state_d = StPayload;
      StPayload: if (push && (in_cnt_q == CntW'(1))) state_d = StDrain;
      StDrain:   state_d = StDrain;
      default:   state_d = StHdr;
    endcase
    if (last_pop) state_d = StHdr;
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= StHdr;
    else       state_q <= state_d;
  end

  // Header latch, frame counters and status pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_q        <= '0;
      col_q        <= '0;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      hdr_err_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      hdr_err_q    <= hdr_acc && !hdr_ok;
      frame_done_q <= last_pop;
      if (hdr_acc && hdr_ok) begin
        row_q     <= hdr_row;
        col_q     <= hdr_col;
        in_cnt_q  <= frame_len;
        out_cnt_q <= frame_len;
      end else begin
        if (push) in_cnt_q  <= in_cnt_q - CntW'(1);
        if (pop)  out_cnt_q <= out_cnt_q - CntW'(1);
      end
    end
  end

  // Two-entry payload FIFO; push and pop at count 1 leave the count unchanged.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// tb_matrix_loader: directed frames with a cycle-level reference of the loader's
// handshake behaviour plus hand-computed end-of-test expectations.
module tb_matrix_loader;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_rdy;
  logic [2:0] row, col;
  logic [7:0] out_data;
  logic       out_valid, out_rdy, out_last;
  logic       hdr_err, frame_done, busy;

  int errors = 0;
  int checks = 0;

  // Reference state.
  bit         need_hdr;
  int         rem_in, rem_out, cnt;
  bit         fd_exp, err_exp;
  logic [2:0] exp_row, exp_col;
  logic [7:0] bufq[$];
  logic [7:0] in_q[$];
  logic [7:0] got[$];
  bit         got_last[$];
  int         n_done, n_err;

  matrix_loader #(.DATA_WIDTH(8), .R_WIDTH(3), .C_WIDTH(3)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_rdy     (in_rdy),
    .row        (row),
    .col        (col),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_rdy    (out_rdy),
    .out_last   (out_last),
    .hdr_err    (hdr_err),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    need_hdr = 1'b1;
    rem_in   = 0;
    rem_out  = 0;
    cnt      = 0;
    fd_exp   = 1'b0;
    err_exp  = 1'b0;
    exp_row  = 3'd0;
    exp_col  = 3'd0;
    bufq.delete();
  endtask

  task automatic clear_log();
    got.delete();
    got_last.delete();
    n_done = 0;
    n_err  = 0;
  endtask

  // Called at posedge+1; drives one cycle per iteration, samples at negedge.
  task automatic run(input int ncyc, input logic [3:0] rdy_pat, input logic [3:0] vld_pat);
    for (int i = 0; i < ncyc; i++) begin
      logic [7:0] d;
      bit         was_hdr, do_push, do_pop;
      in_valid = (in_q.size() != 0) && vld_pat[i % 4];
      in_data  = (in_q.size() != 0) ? in_q[0] : 8'h00;
      out_rdy  = rdy_pat[i % 4];
      @(negedge clk);
      chk("in_rdy", in_rdy, need_hdr || (rem_in != 0 && cnt < 2));
      chk("out_valid", out_valid, cnt != 0);
      if (cnt != 0) begin
        chk("out_data", out_data, bufq[0]);
        chk("out_last", out_last, rem_out == 1);
      end else begin
        chk("out_last_idle", out_last, 0);
      end
      chk("frame_done", frame_done, fd_exp);
      chk("hdr_err", hdr_err, err_exp);
      chk("busy", busy, !need_hdr);
      chk("row", row, exp_row);
      chk("col", col, exp_col);
      if (frame_done) n_done++;
      if (hdr_err) n_err++;
      fd_exp  = 1'b0;
      err_exp = 1'b0;
      was_hdr = need_hdr;
      do_push = in_valid && (need_hdr || (rem_in != 0 && cnt < 2));
      do_pop  = (cnt != 0) && out_rdy;
      d       = in_data;
      if (do_pop) begin
        got.push_back(bufq.pop_front());
        got_last.push_back(rem_out == 1);
        cnt--;
        rem_out--;
        if (rem_out == 0) begin
          fd_exp   = 1'b1;
          need_hdr = 1'b1;
        end
      end
      if (do_push) begin
        void'(in_q.pop_front());
        if (was_hdr) begin
          if (d[5:3] == 3'd0 || d[2:0] == 3'd0) begin
            err_exp = 1'b1;
          end else begin
            exp_row  = d[5:3];
            exp_col  = d[2:0];
            rem_in   = int'(d[5:3]) * int'(d[2:0]);
            rem_out  = rem_in;
            need_hdr = 1'b0;
          end
        end else begin
          bufq.push_back(d);
          cnt++;
          rem_in--;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("stream_consumed", in_q.size(), 0);
  endtask

  initial begin
    rstn     = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    out_rdy  = 1'b0;
    model_reset();
    clear_log();
    #2;
    chk("rst_in_rdy", in_rdy, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_row", row, 0);
    chk("rst_col", col, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // 2x3 frame at full throughput.
    in_q = '{8'h13, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    run(12, 4'b1111, 4'b1111);
    chk("t1_count", got.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk("t1_data", got[i], i + 1);
      chk("t1_last", got_last[i], i == 5);
    end
    chk("t1_done", n_done, 1);
    chk("t1_row", row, 2);
    chk("t1_col", col, 3);

    // Bad header (col=0) dropped, then a 1x1 frame.
    clear_log();
    in_q = '{8'h18, 8'h09, 8'hAA};
    run(8, 4'b1111, 4'b1111);
    chk("t2_err", n_err, 1);
    chk("t2_count", got.size(), 1);
    chk("t2_data", got[0], 8'hAA);
    chk("t2_last", got_last[0], 1);
    chk("t2_done", n_done, 1);

    // 3x3 frame with output stalls and input gaps.
    clear_log();
    in_q = '{8'h1B, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    run(50, 4'b1001, 4'b1011);
    chk("t3_count", got.size(), 9);
    for (int i = 0; i < 9; i++) chk("t3_data", got[i], i + 1);
    chk("t3_done", n_done, 1);

    // Back-to-back 2x2 then 3x1 with continuous in_valid.
    clear_log();
    in_q = '{8'h12, 8'd1, 8'd2, 8'd3, 8'd4, 8'h19, 8'd11, 8'd12, 8'd13};
    run(20, 4'b1111, 4'b1111);
    chk("t4_count", got.size(), 7);
    chk("t4_d3", got[3], 4);
    chk("t4_last3", got_last[3], 1);
    chk("t4_d4", got[4], 11);
    chk("t4_d6", got[6], 13);
    chk("t4_done", n_done, 2);
    chk("t4_row", row, 3);
    chk("t4_col", col, 1);

    // Reset in the middle of a 3x3 frame.
    clear_log();
    in_q = '{8'h1B, 8'd1, 8'd2, 8'd3, 8'd4};
    run(5, 4'b1111, 4'b1111);
    rstn = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_last", out_last, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_row", row, 0);
    chk("mid_rst_col", col, 0);
    chk("mid_rst_in_rdy", in_rdy, 1);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    model_reset();
    clear_log();
    in_q = '{8'h0A, 8'h55, 8'h66};
    run(8, 4'b1111, 4'b1111);
    chk("t5_count", got.size(), 2);
    chk("t5_d0", got[0], 8'h55);
    chk("t5_d1", got[1], 8'h66);
    chk("t5_last", got_last[1], 1);
    chk("t5_row", row, 1);
    chk("t5_col", col, 2);

    // Largest 7x7 frame.
    clear_log();
    in_q.push_back(8'h3F);
    for (int i = 1; i <= 49; i++) in_q.push_back(8'(i));
    run(60, 4'b1111, 4'b1111);
    chk("t6_count", got.size(), 49);
    begin
      int nl = 0;
      foreach (got_last[i]) if (got_last[i]) nl++;
      chk("t6_nlast", nl, 1);
    end
    chk("t6_last49", got_last[48], 1);
    chk("t6_d49", got[48], 49);
    chk("t6_done", n_done, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
